// File: rtl/ndata_stream_arbiter_if.sv
// Valid/ready beat stream carrying NUM_ELEMENTS elements with per-element keep and an end-of-stream flag.
interface ndata_i #(
    parameter type data_t       = logic [15:0],
    parameter int  NUM_ELEMENTS = 4
);
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_stream_arbiter.sv
// Round-robin, stream-granular arbiter in front of a shared normalizer; an ID FIFO tags each
// in-flight stream with its source so the normalizer output can be demultiplexed downstream.
module ndata_stream_arbiter #(
    parameter type data_t        = logic [15:0],
    parameter int  NUM_ELEMENTS  = 4,
    parameter int  NUM_INPUTS    = 4,
    parameter int  ID_FIFO_DEPTH = 4,
    localparam int ID_W          = $clog2(NUM_INPUTS)
) (
    input  logic            clk,
    input  logic            rst_n,
    ndata_i.s               in [NUM_INPUTS],
    ndata_i.m               norm_in,
    ndata_i.s               norm_out,
    ndata_i.m               out,
    output logic [ID_W-1:0] out_id,
    output logic            orphan_err
);
    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
    localparam int CNT_W = $clog2(ID_FIFO_DEPTH + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                   state, state_nxt;
    logic [ID_W-1:0]          gnt, rr_ptr, pick_idx;
    logic                     pick_found, grant_go, release_go;
    logic [ID_W-1:0]          fifo_mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_nonempty, pop;

    data_t [NUM_ELEMENTS-1:0] in_data [NUM_INPUTS];
    logic  [NUM_ELEMENTS-1:0] in_keep [NUM_INPUTS];
    logic  [NUM_INPUTS-1:0]   in_last, in_valid, in_ready;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign in_data[i]  = in[i].data;
        assign in_keep[i]  = in[i].keep;
        assign in_last[i]  = in[i].last;
        assign in_valid[i] = in[i].valid;
        assign in[i].ready = in_ready[i];
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_INPUTS) s -= NUM_INPUTS;
        return ID_W'(s);
    endfunction

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        release_go = 1'b0;
        in_ready   = '0;
        case (state)
            IDLE: begin
                if (pick_found && (fifo_count < CNT_W'(ID_FIFO_DEPTH))) begin
                    grant_go  = 1'b1;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                in_ready[gnt] = norm_in.ready;
                if (in_valid[gnt] && norm_in.ready && in_last[gnt]) begin
                    release_go = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign norm_in.data  = in_data[gnt];
    assign norm_in.keep  = in_keep[gnt];
    assign norm_in.last  = in_last[gnt];
    assign norm_in.valid = (state == LOCKED) && in_valid[gnt];

    // Output beats are only released while some stream is accounted for in the ID FIFO.
    assign fifo_nonempty  = (fifo_count != '0);
    assign out.data       = norm_out.data;
    assign out.keep       = norm_out.keep;
    assign out.last       = norm_out.last;
    assign out.valid      = norm_out.valid && fifo_nonempty;
    assign norm_out.ready = out.ready && fifo_nonempty;
    assign out_id         = fifo_mem[rd_ptr];
    assign pop            = out.valid && out.ready && out.last;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            orphan_err <= 1'b0;
            // NOTE: the ID memory is reset because its head drives out_id, which must read 0 after reset.
            for (int i = 0; i < ID_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (grant_go) begin
                gnt              <= pick_idx;
                fifo_mem[wr_ptr] <= pick_idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (release_go) rr_ptr <= wrap_add(gnt, 1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant_go, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (norm_out.valid && !fifo_nonempty) orphan_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ndata_stream_arbiter.sv
// Directed bench: the normalizer is either a pass-through wire or driven directly by the stimulus.
module tb_ndata_stream_arbiter;
    typedef logic [7:0] elem_t;
    localparam int NE    = 2;
    localparam int NI    = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              pass_mode, out_ready, nin_rdy, f_valid, f_last;
    logic [15:0]       f_data;
    logic [1:0]        f_keep;
    logic [NI-1:0]     in_valid, in_last, in_ready;
    logic [15:0]       in_data [NI];
    logic [1:0]        in_keep [NI];
    logic [1:0]        out_id;
    logic              orphan_err;
    int                checks = 0;
    int                errors = 0;

    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) in_if [NI] ();
    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) norm_in_if ();
    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) norm_out_if ();
    ndata_i #(.data_t(elem_t), .NUM_ELEMENTS(NE)) out_if ();

    for (genvar i = 0; i < NI; i++) begin : g_src
        assign in_if[i].data  = in_data[i];
        assign in_if[i].keep  = in_keep[i];
        assign in_if[i].last  = in_last[i];
        assign in_if[i].valid = in_valid[i];
        assign in_ready[i]    = in_if[i].ready;
    end

    assign norm_out_if.data  = pass_mode ? norm_in_if.data  : f_data;
    assign norm_out_if.keep  = pass_mode ? norm_in_if.keep  : f_keep;
    assign norm_out_if.last  = pass_mode ? norm_in_if.last  : f_last;
    assign norm_out_if.valid = pass_mode ? norm_in_if.valid : f_valid;
    assign norm_in_if.ready  = pass_mode ? norm_out_if.ready : nin_rdy;
    assign out_if.ready      = out_ready;

    ndata_stream_arbiter #(
        .data_t(elem_t), .NUM_ELEMENTS(NE), .NUM_INPUTS(NI), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_if), .norm_in(norm_in_if), .norm_out(norm_out_if),
        .out(out_if), .out_id(out_id), .orphan_err(orphan_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic [15:0] d, input logic l);
        in_data[i] = d;
        in_last[i] = l;
    endtask

    task automatic do_reset();
        in_valid = '0;
        nin_rdy  = 1'b0;
        f_valid  = 1'b0;
        f_last   = 1'b0;
        rst_n    = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_mode = 1'b1; out_ready = 1'b1; nin_rdy = 1'b0;
        f_valid = 1'b0; f_last = 1'b0; f_data = '0; f_keep = '0;
        in_valid = '0; in_last = '0;
        for (int i = 0; i < NI; i++) begin in_data[i] = '0; in_keep[i] = 2'b11; end

        // Reset state
        repeat (2) tick();
        check("rst_norm_in_valid", norm_in_if.valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_id", out_id, 0);
        check("rst_orphan", orphan_err, 0);

        // Single 3-beat stream on in[2]; keep patterns pass through untouched
        rst_n = 1'b1;
        set_in(2, 16'h2000, 1'b0);
        in_valid = 4'b0100;
        #1;
        check("t1_arb_cycle", norm_in_if.valid, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_in(2, 16'(16'h2000 + b), b == 2);
            in_keep[2] = (b == 0) ? 2'b11 : (b == 1) ? 2'b00 : 2'b01;
            #1;
            check($sformatf("t1_ready_b%0d", b), in_ready, 32'h4);
            check($sformatf("t1_data_b%0d", b), norm_in_if.data, 16'h2000 + b);
            check($sformatf("t1_keep_b%0d", b), out_if.keep, in_keep[2]);
            check($sformatf("t1_out_id_b%0d", b), out_id, 2);
            check($sformatf("t1_out_valid_b%0d", b), out_if.valid, 1);
            tick();
        end
        in_valid = '0;
        in_keep[2] = 2'b11;
        #1;
        check("t1_idle_after", norm_in_if.valid, 0);
        check("t1_fifo_empty", dut.fifo_count, 0);

        // Four simultaneous requesters, two-beat streams: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NI; i++) set_in(i, 16'(i * 256), 1'b0);
        in_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            automatic int e = k % NI;
            automatic int s = k / NI;
            check($sformatf("t2_bubble_%0d", k), norm_in_if.valid, 0);
            tick();
            for (int b = 0; b < 2; b++) begin
                set_in(e, 16'(e * 256 + s * 16 + b), b == 1);
                #1;
                check($sformatf("t2_ready_%0d_%0d", k, b), in_ready, 32'(1) << e);
                check($sformatf("t2_data_%0d_%0d", k, b), norm_in_if.data, e * 256 + s * 16 + b);
                check($sformatf("t2_out_id_%0d_%0d", k, b), out_id, e);
                tick();
            end
            set_in(e, 16'(e * 256 + (s + 1) * 16), 1'b0);
            #1;
        end
        in_valid = '0;

        // ID FIFO full: third stream waits until the first out.last pops
        do_reset();
        pass_mode = 1'b0; nin_rdy = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_in(i, 16'(16'hA0 + i), 1'b1);
        in_valid = 4'b0111;
        #1;
        tick();
        check("t3_grant0", in_ready, 32'h1);
        tick();
        in_valid[0] = 1'b0;
        #1;
        check("t3_idle0", in_ready, 0);
        tick();
        check("t3_grant1", in_ready, 32'h2);
        tick();
        in_valid[1] = 1'b0;
        #1;
        tick();
        check("t3_full_ready", in_ready, 0);
        check("t3_full_valid", norm_in_if.valid, 0);
        tick();
        check("t3_full_ready2", in_ready, 0);
        check("t3_head_id", out_id, 0);
        out_ready = 1'b1; f_valid = 1'b1; f_last = 1'b1; f_data = 16'h5555; f_keep = 2'b10;
        #1;
        check("t3_out_valid", out_if.valid, 1);
        check("t3_norm_out_ready", norm_out_if.ready, 1);
        check("t3_out_data", out_if.data, 16'h5555);
        tick();
        f_valid = 1'b0;
        #1;
        check("t3_no_grant_on_pop", in_ready, 0);
        tick();
        check("t3_grant2", in_ready, 32'h4);
        check("t3_head_id1", out_id, 1);
        tick();
        in_valid = '0;
        f_valid = 1'b1;
        #1;
        check("t3_drain_id1", out_id, 1);
        tick();
        check("t3_drain_id2", out_id, 2);
        f_valid = 1'b0;
        #1;

        // Backpressure 1010 on norm_in during a 4-beat stream from in[1]; in[3] waits
        do_reset();
        pass_mode = 1'b0; out_ready = 1'b1;
        set_in(1, 16'h1100, 1'b0);
        set_in(3, 16'h3300, 1'b1);
        in_valid = 4'b1010;
        #1;
        tick();
        for (int c = 0; c < 7; c++) begin
            nin_rdy = (c % 2 == 0);
            set_in(1, 16'(16'h1100 + c / 2), c / 2 == 3);
            #1;
            check($sformatf("t4_ready_c%0d", c), in_ready, nin_rdy ? 32'h2 : 32'h0);
            check($sformatf("t4_data_c%0d", c), norm_in_if.data, 16'h1100 + c / 2);
            check($sformatf("t4_valid_c%0d", c), norm_in_if.valid, 1);
            tick();
        end
        in_valid[1] = 1'b0;
        #1;
        check("t4_bubble_valid", norm_in_if.valid, 0);
        check("t4_bubble_ready", in_ready, 0);
        tick();
        check("t4_grant3", in_ready, 32'h8);
        check("t4_data3", norm_in_if.data, 16'h3300);
        tick();
        in_valid = '0;

        // Orphan output: normalizer valid with nothing in flight
        do_reset();
        pass_mode = 1'b0; out_ready = 1'b1;
        f_valid = 1'b1; f_last = 1'b0; f_data = 16'hDEAD;
        #1;
        check("t5_out_valid", out_if.valid, 0);
        check("t5_norm_out_ready", norm_out_if.ready, 0);
        check("t5_orphan_pre", orphan_err, 0);
        tick();
        check("t5_orphan_set", orphan_err, 1);
        f_valid = 1'b0;
        tick();
        check("t5_orphan_sticky", orphan_err, 1);

        // Mid-stream async reset clears pointers; afterwards in[1] wins over in[3]
        pass_mode = 1'b1;
        set_in(2, 16'h2200, 1'b1);
        in_valid = 4'b0100;
        #1;
        tick();
        check("t6_grant2", in_ready, 32'h4);
        tick();
        set_in(3, 16'h3300, 1'b0);
        set_in(1, 16'h1100, 1'b1);
        in_valid = 4'b1000;
        #1;
        tick();
        check("t6_out_id3", out_id, 3);
        tick();
        set_in(3, 16'h3301, 1'b0);
        #1;
        check("t6_beat2_valid", norm_in_if.valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_norm_in_valid", norm_in_if.valid, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_out_valid", out_if.valid, 0);
        check("t6_rst_out_id", out_id, 0);
        check("t6_rst_orphan", orphan_err, 0);
        set_in(3, 16'h3300, 1'b1);
        in_valid = 4'b1010;
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_arb_cycle", norm_in_if.valid, 0);
        tick();
        check("t6_grant1", in_ready, 32'h2);
        check("t6_data1", norm_in_if.data, 16'h1100);
        check("t6_out_id1", out_id, 1);
        tick();
        in_valid = '0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
